// File: rtl/fsm_pkg.sv
// Shared widths, reset state and write-select encodings for the table-driven Moore engine.
package fsm_pkg;

  localparam int IW_DEF          = 2;
  localparam int SW_DEF          = 3;
  localparam int OW_DEF          = 3;
  localparam int CW_DEF          = 8;
  localparam int RESET_STATE_DEF = 0;

  typedef enum logic {
    WR_TRANS = 1'b0,
    WR_OUT   = 1'b1
  } wr_sel_e;

endpackage

// File: rtl/fsm_table_mem.sv
// Transition and output tables: async read, sync write; only the transition valid bits are reset.
module fsm_table_mem
  import fsm_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int SW = SW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tr_we,
  input  logic [SW+IW-1:0] tr_addr,
  input  logic [SW-1:0]    tr_data,
  input  logic             out_we,
  input  logic [SW-1:0]    out_addr,
  input  logic [OW-1:0]    out_data,
  input  logic [SW+IW-1:0] rd_addr,
  output logic [SW-1:0]    rd_next,
  output logic             rd_valid,
  input  logic [SW-1:0]    ord_addr,
  output logic [OW-1:0]    ord_data
);

  localparam int NT = 2 ** (SW + IW);
  localparam int NS = 2 ** SW;

  logic [SW-1:0] tnext [NT];
  logic [OW-1:0] omem  [NS];
  logic [NT-1:0] valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (tr_we) begin
      valid[tr_addr] <= 1'b1;
    end
  end

  // Table payloads survive reset; the cleared valid bits make stale transitions unusable.
  always_ff @(posedge clk) begin
    if (tr_we) tnext[tr_addr] <= tr_data;
    if (out_we) omem[out_addr] <= out_data;
  end

  assign rd_next  = tnext[rd_addr];
  assign rd_valid = valid[rd_addr];
  assign ord_data = omem[ord_addr];

endmodule

// File: rtl/table_moore_fsm.sv
// Run-time programmable Moore engine: state, registered output, sticky error and step counter.
// States are table data, not fixed encodings; RESET_STATE doubles as the invalid-entry fallback.
module table_moore_fsm
  import fsm_pkg::*;
#(
  parameter int IW          = IW_DEF,
  parameter int SW          = SW_DEF,
  parameter int OW          = OW_DEF,
  parameter int CW          = CW_DEF,
  parameter int RESET_STATE = RESET_STATE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step_en,
  input  logic [IW-1:0]    in_sym,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [SW+IW-1:0] wr_addr,
  input  logic [SW-1:0]    wr_next,
  input  logic [OW-1:0]    wr_out,
  input  logic             clr_cnt,
  output logic [SW-1:0]    state,
  output logic [OW-1:0]    out_sym,
  output logic             err,
  output logic             wr_err,
  output logic [CW-1:0]    step_cnt
);

  localparam logic [SW-1:0] RST_ST = SW'(RESET_STATE);

  wr_sel_e       sel;
  logic          step;
  logic          wr_ok;
  logic          tr_we;
  logic          out_we;
  logic [SW-1:0] tbl_next;
  logic          tbl_valid;
  logic [SW-1:0] nxt;
  logic [OW-1:0] nxt_out;

  logic [SW-1:0] state_d;
  logic [OW-1:0] out_d;
  logic          err_d;
  logic          wr_err_d;
  logic [CW-1:0] cnt_d;

  assign sel    = wr_sel_e'(wr_sel);
  assign step   = run & step_en;
  // Gating with reset keeps a write coincident with reset from landing in the tables.
  assign wr_ok  = wr_en & ~run & reset;
  assign tr_we  = wr_ok & (sel == WR_TRANS);
  assign out_we = wr_ok & (sel == WR_OUT);
  assign nxt    = tbl_valid ? tbl_next : RST_ST;

  fsm_table_mem #(
    .IW(IW),
    .SW(SW),
    .OW(OW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .tr_we   (tr_we),
    .tr_addr (wr_addr),
    .tr_data (wr_next),
    .out_we  (out_we),
    .out_addr(wr_addr[SW-1:0]),
    .out_data(wr_out),
    .rd_addr ({state, in_sym}),
    .rd_next (tbl_next),
    .rd_valid(tbl_valid),
    .ord_addr(nxt),
    .ord_data(nxt_out)
  );

  always_comb begin
    state_d  = state;
    out_d    = out_sym;
    err_d    = err;
    cnt_d    = step_cnt;
    wr_err_d = wr_en & run;
    if (step) begin
      state_d = nxt;
      out_d   = nxt_out;
      if (!tbl_valid) err_d = 1'b1;
    end
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (step && (step_cnt != '1)) begin
      cnt_d = step_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RST_ST;
      out_sym  <= '0;
      err      <= 1'b0;
      wr_err   <= 1'b0;
      step_cnt <= '0;
    end else begin
      state    <= state_d;
      out_sym  <= out_d;
      err      <= err_d;
      wr_err   <= wr_err_d;
      step_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_table_moore_fsm.sv
// Directed scenarios plus a randomized run, all checked against an array-based model of the engine.
module tb_table_moore_fsm;

  localparam int IW = 2;
  localparam int SW = 3;
  localparam int OW = 3;
  localparam int CW = 8;
  localparam int RS = 0;
  localparam int NT = 2 ** (SW + IW);
  localparam int NS = 2 ** SW;
  localparam int CMAX = 2 ** CW - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             run = 1'b0;
  logic             step_en = 1'b0;
  logic [IW-1:0]    in_sym = '0;
  logic             wr_en = 1'b0;
  logic             wr_sel = 1'b0;
  logic [SW+IW-1:0] wr_addr = '0;
  logic [SW-1:0]    wr_next = '0;
  logic [OW-1:0]    wr_out = '0;
  logic             clr_cnt = 1'b0;
  logic [SW-1:0]    state;
  logic [OW-1:0]    out_sym;
  logic             err;
  logic             wr_err;
  logic [CW-1:0]    step_cnt;

  table_moore_fsm #(
    .IW(IW), .SW(SW), .OW(OW), .CW(CW), .RESET_STATE(RS)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .step_en(step_en), .in_sym(in_sym),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_next(wr_next),
    .wr_out(wr_out), .clr_cnt(clr_cnt), .state(state), .out_sym(out_sym),
    .err(err), .wr_err(wr_err), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int m_tnext [NT];
  bit m_valid [NT];
  int m_omem  [NS];
  int m_state, m_out, m_cnt;
  bit m_err, m_werr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_valid[i] = 1'b0;
    m_state = RS;
    m_out   = 0;
    m_cnt   = 0;
    m_err   = 1'b0;
    m_werr  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_state));
    chk({tag, ".out"}, 32'(out_sym), 32'(m_out));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".wr_err"}, 32'(wr_err), 32'(m_werr));
    chk({tag, ".cnt"}, 32'(step_cnt), 32'(m_cnt));
  endtask

  // One clock: drive, advance the model by the behavioural rules, then compare away from the edge.
  task automatic cyc(input string tag, input bit r, input bit s, input int sym,
                     input bit we, input bit sel, input int addr, input int nx,
                     input int o, input bit clr);
    int idx;
    run = r; step_en = s; in_sym = IW'(sym); wr_en = we; wr_sel = sel;
    wr_addr = (SW + IW)'(addr); wr_next = SW'(nx); wr_out = OW'(o); clr_cnt = clr;
    @(posedge clk);
    m_werr = we && r;
    if (r && s) begin
      idx = m_state * (2 ** IW) + sym;
      if (m_valid[idx]) begin
        m_state = m_tnext[idx];
      end else begin
        m_state = RS;
        m_err   = 1'b1;
      end
      m_out = m_omem[m_state];
    end
    if (clr) m_cnt = 0;
    else if (r && s && m_cnt < CMAX) m_cnt = m_cnt + 1;
    if (we && !r) begin
      if (!sel) begin
        m_tnext[addr] = nx;
        m_valid[addr] = 1'b1;
      end else begin
        m_omem[addr % NS] = o;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    run = 1'b0; step_en = 1'b0; wr_en = 1'b0; clr_cnt = 1'b0;
  endtask

  // Async reset asserted between edges, optionally while a write strobe is being presented.
  task automatic mid_reset(input string tag, input bit with_wr);
    run = 1'b0; step_en = 1'b0; clr_cnt = 1'b0;
    wr_en = with_wr; wr_sel = 1'b1; wr_addr = '0; wr_out = OW'(3);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_inputs();
    check_all({tag, ".held"});
  endtask

  initial begin
    int prev, st_hold, cnt_hold, guard;
    int exp_s [4] = '{1, 2, 0, 1};
    int exp_o [4] = '{6, 7, 5, 6};

    model_reset();
    for (int i = 0; i < NT; i++) m_tnext[i] = 0;
    for (int i = 0; i < NS; i++) m_omem[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    for (int i = 0; i < NS; i++)
      cyc("prog_out", 0, 0, 0, 1, 1, i, 0, (i < 3) ? 5 + i : $urandom_range(0, 7), 0);

    cyc("t1_step", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_err", 32'(err), 1);
    chk("t1_state", 32'(state), 0);
    chk("t1_out", 32'(out_sym), 5);

    mid_reset("t1_rst", 1'b0);
    cyc("t2_w0", 0, 0, 0, 1, 0, 0, 1, 0, 0);
    cyc("t2_w1", 0, 0, 0, 1, 0, 4, 2, 0, 0);
    cyc("t2_w2", 0, 0, 0, 1, 0, 8, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc("t2_step", 1, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("t2_state", 32'(state), 32'(exp_s[k]));
      chk("t2_out", 32'(out_sym), 32'(exp_o[k]));
    end
    chk("t2_cnt", 32'(step_cnt), 4);
    chk("t2_err", 32'(err), 0);

    cyc("t3_wr_run", 1, 0, 0, 1, 0, 4, 3, 0, 0);
    chk("t3_wr_err", 32'(wr_err), 1);
    cyc("t3_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_wr_err_gone", 32'(wr_err), 0);
    cyc("t3_step", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_state", 32'(state), 2);

    st_hold = 2; cnt_hold = 5;
    for (int k = 0; k < 5; k++)
      cyc("t6_hold", 0, 1, $urandom_range(0, 3), 0, 0, 0, 0, 0, 0);
    chk("t6_state", 32'(state), 32'(st_hold));
    chk("t6_out", 32'(out_sym), 7);
    chk("t6_cnt", 32'(step_cnt), 32'(cnt_hold));

    for (int k = 0; k < 300; k++)
      cyc("t4_run", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_sat", 32'(step_cnt), 32'(CMAX));
    prev = int'(state);
    cyc("t4_clr", 1, 1, 0, 0, 0, 0, 0, 0, 1);
    chk("t4_clr_cnt", 32'(step_cnt), 0);
    chk("t4_adv", 32'(state), 32'((prev + 1) % 3));

    guard = 0;
    while (state != SW'(2) && guard < 5) begin
      cyc("t5_seek", 1, 1, 0, 0, 0, 0, 0, 0, 0);
      guard++;
    end
    chk("t5_at2", 32'(state), 2);
    mid_reset("t5_rst", 1'b1);
    chk("t5_state", 32'(state), 0);
    chk("t5_out", 32'(out_sym), 0);
    cyc("t5_step", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_err", 32'(err), 1);
    chk("t5_out_kept", 32'(out_sym), 5);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        mid_reset("rnd_rst", 1'($urandom_range(0, 1)));
      end else begin
        cyc("rnd", 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0),
            $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            $urandom_range(0, NT - 1), $urandom_range(0, NS - 1), $urandom_range(0, 7),
            1'($urandom_range(0, 31) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
